// File: rtl/game_retract_pkg.sv
// game_retract_pkg: state width, header/map split, history depth and command encodings for the game core
package game_retract_pkg;
  localparam int W = 134;
  localparam int HDR_W = 6;
  localparam int MAP_W = 128;
  localparam int DEPTH = 8;
  typedef enum logic [1:0] {
    SEL_INIT    = 2'd0,
    SEL_MOVE    = 2'd1,
    SEL_RETRACT = 2'd2,
    SEL_HOLD    = 2'd3
  } sel_e;
  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic [MAP_W-1:0] map;
  } state_t;
endpackage

// File: rtl/game_retract_stack.sv
// retract_stack: LIFO of W-bit states, overwrites the oldest when full (ports: clk, rst_n, push, pop, clr, din -> top, empty)
module retract_stack import game_retract_pkg::*; #(
  parameter int W = game_retract_pkg::W,
  parameter int DEPTH = game_retract_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, top_idx;
  logic [PW:0] cnt;
  assign top_idx = ptr - 1'b1;
  assign top = mem[top_idx];
  assign empty = cnt == '0;
  always_ff @(posedge clk)
    if (push) mem[ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (clr) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      cnt <= cnt == FULL ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/game_retract.sv
// game_retract: undo engine holding committed state plus bounded history (ports: clk, rst_n, game_state_en, sel, game_state_int/bm/mm -> game_state, real_retract)
module game_retract import game_retract_pkg::*; #(
  parameter int W = game_retract_pkg::W,
  parameter int DEPTH = game_retract_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         game_state_en,
  input  logic [1:0]   sel,
  input  logic [W-1:0] game_state_int,
  input  logic [W-1:0] game_state_bm,
  input  logic [W-1:0] game_state_mm,
  output logic [W-1:0] game_state,
  output logic         real_retract
);
  logic push, pop, clr, empty;
  logic [W-1:0] top;
  assign clr  = game_state_en && sel == SEL_INIT;
  assign push = game_state_en && sel == SEL_MOVE;
  assign pop  = game_state_en && sel == SEL_RETRACT && !empty;
  retract_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(clr),
    .din(game_state_bm), .top(top), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      game_state <= '0;
      real_retract <= 1'b0;
    end else begin
      real_retract <= pop;
      game_state <= clr ? game_state_int : push ? game_state_mm : pop ? top : game_state;
    end
endmodule

// File: tb/tb_game_retract.sv
// tb_game_retract: randomized and directed checks of game_retract against a queue-based history model
module tb_game_retract;
  import game_retract_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] sel = 2'd3;
  logic [W-1:0] gi = '0, gb = '0, gm = '0, gs;
  logic rr;
  int checks = 0, errors = 0;
  logic [W-1:0] q [$];
  logic [W-1:0] ms = '0;
  logic mr = 1'b0;
  always #5 clk = ~clk;
  game_retract dut (
    .clk(clk), .rst_n(rst_n), .game_state_en(en), .sel(sel),
    .game_state_int(gi), .game_state_bm(gb), .game_state_mm(gm),
    .game_state(gs), .real_retract(rr)
  );
  function automatic logic [W-1:0] h(int k);
    return {k[5:0], {128{1'b1}}};
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction
  task automatic check(string tag);
    checks++;
    assert (gs === ms) else begin
      errors++;
      $error("FAIL %s game_state got %h exp %h", tag, gs, ms);
    end
    checks++;
    assert (rr === mr) else begin
      errors++;
      $error("FAIL %s real_retract got %b exp %b", tag, rr, mr);
    end
  endtask
  task automatic cyc(string tag, logic e, logic [1:0] s, logic [W-1:0] i, logic [W-1:0] b, logic [W-1:0] m);
    en = e; sel = s; gi = i; gb = b; gm = m;
    @(posedge clk);
    mr = 1'b0;
    if (e)
      case (s)
        2'd0: begin ms = i; q.delete(); end
        2'd1: begin ms = m; q.push_back(b); if (q.size() > DEPTH) void'(q.pop_front()); end
        2'd2: if (q.size() > 0) begin ms = q.pop_back(); mr = 1'b1; end
        default: ;
      endcase
    @(negedge clk);
    check(tag);
  endtask
  initial begin
    @(negedge clk);
    check("reset");
    rst_n = 1'b1;
    cyc("t1_init", 1, 0, h(0), '0, '0);
    cyc("t2_move", 1, 1, '0, h(1), h(2));
    cyc("t2_retract", 1, 2, '0, '0, '0);
    cyc("t2_idle", 0, 2, '0, '0, '0);
    cyc("t3_init", 1, 0, h(0), '0, '0);
    cyc("t3_move1", 1, 1, '0, h(1), h(2));
    cyc("t3_move2", 1, 1, '0, h(3), h(4));
    cyc("t3_ret1", 1, 2, '0, '0, '0);
    cyc("t3_ret2", 1, 2, '0, '0, '0);
    cyc("t3_ret_empty", 1, 2, '0, '0, '0);
    checks++;
    assert (gs === h(1)) else begin
      errors++;
      $error("FAIL t3_final got %h exp %h", gs, h(1));
    end
    for (int k = 0; k < 6; k++) cyc("t4_hold", 1, 3, rnd(), rnd(), rnd());
    cyc("t4_init", 1, 0, h(9), '0, '0);
    for (int k = 1; k <= DEPTH + 2; k++) cyc("t5_move", 1, 1, '0, h(k), h(k + 20));
    for (int k = 0; k <= DEPTH; k++) cyc("t5_retract", 1, 2, '0, '0, '0);
    checks++;
    assert (gs === h(3)) else begin
      errors++;
      $error("FAIL t5_oldest got %h exp %h", gs, h(3));
    end
    cyc("t6_move1", 1, 1, '0, h(5), h(6));
    cyc("t6_move2", 1, 1, '0, h(7), h(8));
    #2 rst_n = 1'b0;
    #1 ms = '0; mr = 1'b0; q.delete();
    check("t6_async_reset");
    #1 rst_n = 1'b1;
    cyc("t6_retract", 1, 2, '0, '0, '0);
    for (int k = 0; k < 400; k++) begin
      logic e;
      logic [1:0] s;
      e = $urandom_range(0, 3) != 0;
      s = $urandom_range(0, 9) == 0 ? 2'd0 : 2'($urandom_range(1, 3));
      cyc("random", e, s, rnd(), rnd(), rnd());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
